// File: rtl/fft_pingpong_buffer_pkg.sv
// Shared definitions for the FFT ping-pong sample buffer.
//   - default data/address widths and the derived word width / block length
//   - field offsets of the real (low) and imaginary (high) halves of a word
//   - control state encoding shared by the top level
//   - bit-reverse helper used to generate the fill address
package fft_pingpong_buffer_pkg;

  localparam int DW_DEF = 13;
  localparam int AW_DEF = 7;
  localparam int WORD_W = 2 * DW_DEF;
  localparam int N      = 1 << AW_DEF;
  localparam int RE_LSB = 0;

  // FILL: no bank owned by the FFT core.
  // PROC: FFT core owns proc_bank, the other bank is filling.
  // PEND: FFT core still busy and the fill bank is complete, input stalled.
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PROC = 2'd1,
    ST_PEND = 2'd2
  } buf_state_e;

  function automatic int word_width(input int dw);
    return 2 * dw;
  endfunction

  function automatic int block_len(input int aw);
    return 1 << aw;
  endfunction

  // The imaginary half sits directly above the real half.
  function automatic int im_lsb(input int dw);
    return RE_LSB + dw;
  endfunction

  // Reverses the lowest 'width' bits of 'value'; upper bits return as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < width; i++) begin
      r[i] = value[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_buffer_if.sv
// Bus bundle between the sample source / FFT core and the ping-pong buffer.
//   in_valid/in_re/in_im/in_ready : sample stream into the fill bank
//   fft_start/fft_done/fft_busy   : bank handover handshake with the FFT core
//   a_* / b_*                     : two independent FFT-side RAM ports
// Modport 'slave' is the buffer side, 'master' the source/FFT side.
interface fft_pingpong_buffer_if
  import fft_pingpong_buffer_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) ();

  logic              in_valid;
  logic [DW-1:0]     in_re;
  logic [DW-1:0]     in_im;
  logic              in_ready;
  logic              fft_start;
  logic              fft_done;
  logic              fft_busy;
  logic              a_en;
  logic              a_we;
  logic [AW-1:0]     a_addr;
  logic [2*DW-1:0]   a_din;
  logic [2*DW-1:0]   a_dout;
  logic              b_en;
  logic              b_we;
  logic [AW-1:0]     b_addr;
  logic [2*DW-1:0]   b_din;
  logic [2*DW-1:0]   b_dout;

  modport slave (
    input  in_valid, in_re, in_im, fft_done,
    input  a_en, a_we, a_addr, a_din,
    input  b_en, b_we, b_addr, b_din,
    output in_ready, fft_start, fft_busy, a_dout, b_dout
  );

  modport master (
    output in_valid, in_re, in_im, fft_done,
    output a_en, a_we, a_addr, a_din,
    output b_en, b_we, b_addr, b_din,
    input  in_ready, fft_start, fft_busy, a_dout, b_dout
  );

endinterface

// File: rtl/fft_pingpong_buffer_ram_dp_param.sv
// True dual-port RAM, one bank of the ping-pong buffer.
//   clk              : rising-edge clock
//   en0/we0/addr0/din0/dout0 : port 0 (fill writes or FFT port A)
//   en1/we1/addr1/din1/dout1 : port 1 (FFT port B)
// Reads have one cycle of latency and return the word before any write of
// the same cycle. When both ports write one address, port 1 wins.
// dout holds whenever its port is not enabled.
module ram_dp_param
  import fft_pingpong_buffer_pkg::*;
#(
  parameter int DW2 = WORD_W,
  parameter int AW  = AW_DEF
) (
  input  logic           clk,
  input  logic           en0,
  input  logic           we0,
  input  logic [AW-1:0]  addr0,
  input  logic [DW2-1:0] din0,
  output logic [DW2-1:0] dout0,
  input  logic           en1,
  input  logic           we1,
  input  logic [AW-1:0]  addr1,
  input  logic [DW2-1:0] din1,
  output logic [DW2-1:0] dout1
);

  localparam int DEPTH = block_len(AW);

  logic [DW2-1:0] mem [DEPTH];
  logic [DW2-1:0] dout0_q, dout0_d;
  logic [DW2-1:0] dout1_q, dout1_d;

  always_comb begin
    dout0_d = dout0_q;
    dout1_d = dout1_q;
    if (en0) dout0_d = mem[addr0];
    if (en1) dout1_d = mem[addr1];
  end

  always_ff @(posedge clk) begin
    dout0_q <= dout0_d;
    dout1_q <= dout1_d;
  end

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (en0 && we0) mem[addr0] <= din0;
    if (en1 && we1) mem[addr1] <= din1;
  end

  assign dout0 = dout0_q;
  assign dout1 = dout1_q;

endmodule

// File: rtl/fft_pingpong_buffer.sv
// Double-banked complex sample store between the sample source and the FFT.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : fft_pingpong_buffer_if.slave (stream in, handover, ports A/B)
// One bank fills from the stream (optionally at bit-reversed addresses) while
// the FFT core owns the other through ports A and B. A completed block is
// handed over immediately if the core is free (or releasing this cycle),
// otherwise it is held and the stream is stalled until fft_done.
module fft_pingpong_buffer
  import fft_pingpong_buffer_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int BITREV = 1
) (
  input logic clk,
  input logic rst_n,
  fft_pingpong_buffer_if.slave bus
);

  localparam int WW = word_width(DW);

  buf_state_e    state_q, state_d;
  logic [AW-1:0] count_q, count_d;
  logic          wr_bank_q, wr_bank_d;
  logic          proc_bank_q, proc_bank_d;
  logic          start_q, start_d;
  logic          a_rd_q, a_rd_d;
  logic          b_rd_q, b_rd_d;
  logic          a_sel_q, a_sel_d;
  logic          b_sel_q, b_sel_d;
  logic [WW-1:0] a_hold_q, a_hold_d;
  logic [WW-1:0] b_hold_q, b_hold_d;

  logic          busy, full, in_ready, accept, block_done, handover;
  logic [AW-1:0] fill_addr;
  logic [WW-1:0] fill_word;
  logic [WW-1:0] a_dout_w, b_dout_w;

  logic [1:0]           p0_en, p0_we, p1_en, p1_we;
  logic [1:0][AW-1:0]   p0_addr, p1_addr;
  logic [1:0][WW-1:0]   p0_din, p1_din;
  logic [WW-1:0]        bank0_dout0, bank0_dout1, bank1_dout0, bank1_dout1;

  assign busy       = (state_q != ST_FILL);
  assign full       = (state_q == ST_PEND);
  assign in_ready   = !full;
  assign accept     = bus.in_valid && in_ready;
  assign block_done = accept && (count_q == '1);

  always_comb begin
    fill_word = '0;
    fill_word[RE_LSB +: DW]     = bus.in_re;
    fill_word[im_lsb(DW) +: DW] = bus.in_im;
    if (BITREV != 0) fill_addr = AW'(bit_reverse(32'(count_q), AW));
    else             fill_addr = count_q;
  end

  // Handover and release control. A completed block moves straight to the
  // FFT when it is free or releasing in the same cycle; otherwise it waits.
  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    proc_bank_d = proc_bank_q;
    start_d     = 1'b0;
    handover    = 1'b0;
    count_d     = accept ? count_q + 1'b1 : count_q;
    case (state_q)
      ST_FILL: begin
        if (block_done) begin
          handover = 1'b1;
          state_d  = ST_PROC;
        end
      end
      ST_PROC: begin
        if (block_done) begin
          if (bus.fft_done) handover = 1'b1;
          else              state_d  = ST_PEND;
        end else if (bus.fft_done) begin
          state_d = ST_FILL;
        end
      end
      ST_PEND: begin
        if (bus.fft_done) begin
          handover = 1'b1;
          state_d  = ST_PROC;
        end
      end
      default: state_d = ST_FILL;
    endcase
    if (handover) begin
      proc_bank_d = wr_bank_q;
      wr_bank_d   = ~wr_bank_q;
      start_d     = 1'b1;
    end
  end

  // Port 0 of the fill bank takes stream writes; port 0 of the processing
  // bank serves FFT port A. The two banks are always distinct while busy.
  always_comb begin
    p0_en = '0; p0_we = '0; p0_addr = '0; p0_din = '0;
    p1_en = '0; p1_we = '0; p1_addr = '0; p1_din = '0;
    for (int i = 0; i < 2; i++) begin
      if (accept && (wr_bank_q == 1'(i))) begin
        p0_en[i]   = 1'b1;
        p0_we[i]   = 1'b1;
        p0_addr[i] = fill_addr;
        p0_din[i]  = fill_word;
      end else if (busy && (proc_bank_q == 1'(i))) begin
        p0_en[i]   = bus.a_en;
        p0_we[i]   = bus.a_we;
        p0_addr[i] = bus.a_addr;
        p0_din[i]  = bus.a_din;
      end
      if (busy && (proc_bank_q == 1'(i))) begin
        p1_en[i]   = bus.b_en;
        p1_we[i]   = bus.b_we;
        p1_addr[i] = bus.b_addr;
        p1_din[i]  = bus.b_din;
      end
    end
  end

  // A bank's port-0 output also moves on fill writes, so the visible dout
  // shows fresh RAM data only right after an FFT access and a held copy
  // otherwise.
  always_comb begin
    a_rd_d   = bus.a_en && busy;
    b_rd_d   = bus.b_en && busy;
    a_sel_d  = proc_bank_q;
    b_sel_d  = proc_bank_q;
    a_dout_w = a_hold_q;
    b_dout_w = b_hold_q;
    if (a_rd_q) a_dout_w = a_sel_q ? bank1_dout0 : bank0_dout0;
    if (b_rd_q) b_dout_w = b_sel_q ? bank1_dout1 : bank0_dout1;
    a_hold_d = a_dout_w;
    b_hold_d = b_dout_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      count_q     <= '0;
      wr_bank_q   <= 1'b0;
      proc_bank_q <= 1'b0;
      start_q     <= 1'b0;
      a_rd_q      <= 1'b0;
      b_rd_q      <= 1'b0;
      a_sel_q     <= 1'b0;
      b_sel_q     <= 1'b0;
      a_hold_q    <= '0;
      b_hold_q    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_bank_q   <= wr_bank_d;
      proc_bank_q <= proc_bank_d;
      start_q     <= start_d;
      a_rd_q      <= a_rd_d;
      b_rd_q      <= b_rd_d;
      a_sel_q     <= a_sel_d;
      b_sel_q     <= b_sel_d;
      a_hold_q    <= a_hold_d;
      b_hold_q    <= b_hold_d;
    end
  end

  ram_dp_param #(.DW2(WW), .AW(AW)) u_bank0 (
    .clk   (clk),
    .en0   (p0_en[0]),   .we0 (p0_we[0]),   .addr0 (p0_addr[0]),
    .din0  (p0_din[0]),  .dout0 (bank0_dout0),
    .en1   (p1_en[0]),   .we1 (p1_we[0]),   .addr1 (p1_addr[0]),
    .din1  (p1_din[0]),  .dout1 (bank0_dout1)
  );

  ram_dp_param #(.DW2(WW), .AW(AW)) u_bank1 (
    .clk   (clk),
    .en0   (p0_en[1]),   .we0 (p0_we[1]),   .addr0 (p0_addr[1]),
    .din0  (p0_din[1]),  .dout0 (bank1_dout0),
    .en1   (p1_en[1]),   .we1 (p1_we[1]),   .addr1 (p1_addr[1]),
    .din1  (p1_din[1]),  .dout1 (bank1_dout1)
  );

  assign bus.in_ready  = in_ready;
  assign bus.fft_start = start_q;
  assign bus.fft_busy  = busy;
  assign bus.a_dout    = a_dout_w;
  assign bus.b_dout    = b_dout_w;

endmodule

// File: tb/tb_fft_pingpong_buffer.sv
// Testbench for fft_pingpong_buffer with AW=3, DW=13. Two instances run the
// same stimulus, one filling at bit-reversed addresses and one in natural
// order. A block-level model (sample order, bank images, busy/pending flags)
// predicts every output each cycle; directed checks cover the key scenarios.
module tb_fft_pingpong_buffer;

  localparam int DW = 13;
  localparam int AW = 3;
  localparam int NB = 8;

  logic clk;
  logic rst_n;

  fft_pingpong_buffer_if #(.DW(DW), .AW(AW)) ifRev ();
  fft_pingpong_buffer_if #(.DW(DW), .AW(AW)) ifNat ();

  fft_pingpong_buffer #(.DW(DW), .AW(AW), .BITREV(1)) dutRev (
    .clk (clk), .rst_n (rst_n), .bus (ifRev)
  );

  fft_pingpong_buffer #(.DW(DW), .AW(AW), .BITREV(0)) dutNat (
    .clk (clk), .rst_n (rst_n), .bus (ifNat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;

  // Reference model: inst 0 = bit-reversed, inst 1 = natural order.
  logic [25:0] fillImg [2][NB];
  logic [25:0] pendImg [2][NB];
  logic [25:0] procImg [2][NB];
  logic [25:0] aDoutM [2];
  logic [25:0] bDoutM [2];
  logic busyM, fullM, startM;
  int   cnt;

  // Currently applied inputs.
  logic sValid, sDone, sAEn, sAWe, sBEn, sBWe;
  logic [DW-1:0] sRe, sIm;
  logic [AW-1:0] sAAddr, sBAddr;
  logic [25:0] sADin, sBDin;

  function automatic logic [25:0] mkWord(input int re, input int im);
    logic [12:0] r;
    logic [12:0] i;
    r = 13'(re);
    i = 13'(im);
    return {i, r};
  endfunction

  function automatic int revIdx(input int k);
    int r;
    r = 0;
    for (int b = 0; b < AW; b++) if (((k >> b) & 1) != 0) r = r | (1 << (AW - 1 - b));
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    busyM = 1'b0; fullM = 1'b0; startM = 1'b0; cnt = 0;
    for (int n = 0; n < 2; n++) begin
      aDoutM[n] = '0;
      bDoutM[n] = '0;
    end
  endtask

  task automatic modelStep();
    logic acc;
    logic blk;
    acc = sValid && !fullM;
    blk = 1'b0;
    if (busyM) begin
      for (int n = 0; n < 2; n++) begin
        if (sAEn) aDoutM[n] = procImg[n][sAAddr];
        if (sBEn) bDoutM[n] = procImg[n][sBAddr];
        if (sAEn && sAWe) procImg[n][sAAddr] = sADin;
        if (sBEn && sBWe) procImg[n][sBAddr] = sBDin;
      end
    end
    if (acc) begin
      fillImg[0][revIdx(cnt)] = {sIm, sRe};
      fillImg[1][cnt]         = {sIm, sRe};
      cnt++;
      if (cnt == NB) begin
        cnt = 0;
        blk = 1'b1;
      end
    end
    startM = 1'b0;
    if (blk) begin
      if (!busyM || sDone) begin
        procImg = fillImg; busyM = 1'b1; startM = 1'b1;
      end else begin
        pendImg = fillImg; fullM = 1'b1;
      end
    end else if (fullM && sDone) begin
      procImg = pendImg; fullM = 1'b0; startM = 1'b1;
    end else if (busyM && sDone) begin
      busyM = 1'b0;
    end
  endtask

  task automatic checkAll();
    checkOutput("rev.in_ready",  32'(ifRev.in_ready),  32'(!fullM));
    checkOutput("rev.fft_start", 32'(ifRev.fft_start), 32'(startM));
    checkOutput("rev.fft_busy",  32'(ifRev.fft_busy),  32'(busyM));
    checkOutput("rev.a_dout",    32'(ifRev.a_dout),    32'(aDoutM[0]));
    checkOutput("rev.b_dout",    32'(ifRev.b_dout),    32'(bDoutM[0]));
    checkOutput("nat.in_ready",  32'(ifNat.in_ready),  32'(!fullM));
    checkOutput("nat.fft_start", 32'(ifNat.fft_start), 32'(startM));
    checkOutput("nat.fft_busy",  32'(ifNat.fft_busy),  32'(busyM));
    checkOutput("nat.a_dout",    32'(ifNat.a_dout),    32'(aDoutM[1]));
    checkOutput("nat.b_dout",    32'(ifNat.b_dout),    32'(bDoutM[1]));
  endtask

  task automatic driveInputs();
    ifRev.in_valid = sValid; ifNat.in_valid = sValid;
    ifRev.in_re = sRe;       ifNat.in_re = sRe;
    ifRev.in_im = sIm;       ifNat.in_im = sIm;
    ifRev.fft_done = sDone;  ifNat.fft_done = sDone;
    ifRev.a_en = sAEn;       ifNat.a_en = sAEn;
    ifRev.a_we = sAWe;       ifNat.a_we = sAWe;
    ifRev.a_addr = sAAddr;   ifNat.a_addr = sAAddr;
    ifRev.a_din = sADin;     ifNat.a_din = sADin;
    ifRev.b_en = sBEn;       ifNat.b_en = sBEn;
    ifRev.b_we = sBWe;       ifNat.b_we = sBWe;
    ifRev.b_addr = sBAddr;   ifNat.b_addr = sBAddr;
    ifRev.b_din = sBDin;     ifNat.b_din = sBDin;
  endtask

  // Applies one cycle of inputs (called at a falling edge), advances the
  // model at the rising edge and checks all outputs at the next falling edge.
  task automatic applyStimulus(input logic v, input int re, input int im, input logic done,
                               input logic aEn, input logic aWe, input int aAddr, input logic [25:0] aDin,
                               input logic bEn, input logic bWe, input int bAddr, input logic [25:0] bDin);
    sValid = v; sRe = DW'(re); sIm = DW'(im); sDone = done;
    sAEn = aEn; sAWe = aWe; sAAddr = AW'(aAddr); sADin = aDin;
    sBEn = bEn; sBWe = bWe; sBAddr = AW'(bAddr); sBDin = bDin;
    driveInputs();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic pushSample(input int re, input int im, input logic done);
    applyStimulus(1'b1, re, im, done, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic idleCycle(input logic done);
    applyStimulus(1'b0, 0, 0, done, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic readA(input int addr);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, addr, '0, 1'b0, 1'b0, 0, '0);
  endtask

  int startCount;

  initial begin
    rst_n = 1'b0;
    sValid = 0; sRe = '0; sIm = '0; sDone = 0; sAEn = 0; sAWe = 0; sAAddr = '0; sADin = '0;
    sBEn = 0; sBWe = 0; sBAddr = '0; sBDin = '0;
    driveInputs();
    modelReset();
    repeat (3) @(negedge clk);
    checkAll();
    rst_n = 1'b1;

    // Block 1: re=k, im=-k.
    for (int k = 0; k < NB; k++) pushSample(k, -k, 1'b0);
    checkOutput("blk1.start", 32'(ifRev.fft_start), 32'd1);
    idleCycle(1'b0);
    checkOutput("blk1.start_once", 32'(ifRev.fft_start), 32'd0);
    readA(1);
    checkOutput("blk1.rev_addr1", 32'(ifRev.a_dout), 32'(mkWord(4, -4)));
    checkOutput("blk1.nat_addr1", 32'(ifNat.a_dout), 32'(mkWord(1, -1)));
    readA(6);
    checkOutput("blk1.nat_addr6", 32'(ifNat.a_dout), 32'(mkWord(6, -6)));
    checkOutput("blk1.rev_addr6", 32'(ifRev.a_dout), 32'(mkWord(3, -3)));

    // Block 2 while busy: stalls until fft_done.
    for (int k = 0; k < NB; k++) pushSample(10 + k, -(10 + k), 1'b0);
    checkOutput("blk2.stall", 32'(ifRev.in_ready), 32'd0);
    pushSample(99, 99, 1'b0);
    idleCycle(1'b1);
    checkOutput("blk2.start", 32'(ifRev.fft_start), 32'd1);
    checkOutput("blk2.ready", 32'(ifRev.in_ready), 32'd1);
    readA(1);
    checkOutput("blk2.rev_addr1", 32'(ifRev.a_dout), 32'(mkWord(14, -14)));

    // Block 3 with fft_done on the final accept.
    for (int k = 0; k < NB - 1; k++) pushSample(20 + k, -(20 + k), 1'b0);
    pushSample(27, -27, 1'b1);
    checkOutput("blk3.start", 32'(ifRev.fft_start), 32'd1);
    checkOutput("blk3.ready", 32'(ifRev.in_ready), 32'd1);

    // Port collision on addr 5, then read-before-write on addr 2.
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 5, 26'h3FFFFFF, 1'b1, 1'b1, 5, 26'h0000001);
    readA(5);
    checkOutput("coll.rev", 32'(ifRev.a_dout), 32'h0000001);
    checkOutput("coll.nat", 32'(ifNat.a_dout), 32'h0000001);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 2, 26'h1234567, 1'b0, 1'b0, 0, '0);
    checkOutput("rbw.rev", 32'(ifRev.a_dout), 32'(mkWord(22, -22)));
    readA(2);
    checkOutput("rbw.new", 32'(ifRev.a_dout), 32'h1234567);
    idleCycle(1'b1);
    checkOutput("release", 32'(ifRev.fft_busy), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)),
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                    26'($urandom),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                    26'($urandom));
    end
    idleCycle(1'b0);

    // Reset after 5 samples of a block.
    for (int k = 0; k < 5; k++) pushSample(40 + k, -(40 + k), 1'b0);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    startCount = 0;
    for (int k = 0; k < NB; k++) begin
      pushSample(50 + k, -(50 + k), 1'b0);
      if (ifRev.fft_start) startCount++;
    end
    for (int k = 0; k < 3; k++) begin
      idleCycle(1'b0);
      if (ifRev.fft_start) startCount++;
    end
    checkOutput("rst.one_start", 32'(startCount), 32'd1);
    readA(0);
    checkOutput("rst.rev_addr0", 32'(ifRev.a_dout), 32'(mkWord(50, -50)));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
